// File: rtl/serial_addsub_ctrl.sv
// serial_addsub_ctrl: bit-serial adder/subtractor built around one full_adder_1bit cell.
// Each operation takes WIDTH cycles in RUN, one bit per cycle, LSB first.
// Subtraction is A + ~B + 1: the B operand is inverted at capture and the carry is seeded with 1.
//
// Ports:
//   clk_i     rising-edge clock
//   rst_ni    asynchronous active-low reset
//   start_i   operation request, sampled only in IDLE
//   sub_i     0 = add (A+B), 1 = subtract (A-B), captured with start_i
//   a_i, b_i  WIDTH-bit operands, captured with start_i
//   busy_o    high while the operation runs
//   done_o    one-cycle completion pulse
//   result_o  sum/difference mod 2^WIDTH, held until the next operation completes
//   cout_o    add: carry out; sub: borrow (unsigned a < b)
//   ovf_o     two's-complement signed overflow

// 1-bit full adder cell shared across all bit positions.
module full_adder_1bit (
    input  logic a_i,
    input  logic b_i,
    input  logic ci_i,
    output logic s_o,
    output logic co_o
);
    assign s_o  = a_i ^ b_i ^ ci_i;
    assign co_o = (a_i & b_i) | (ci_i & (a_i ^ b_i));
endmodule

module serial_addsub_ctrl #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             sub_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             cout_o,
    output logic             ovf_o
);
    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   shift_a_q, shift_a_d;
    logic [WIDTH-1:0]   shift_b_q, shift_b_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic               op_sub_q, op_sub_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;

    logic               fa_s, fa_co;

    full_adder_1bit u_fa (
        .a_i  (shift_a_q[0]),
        .b_i  (shift_b_q[0]),
        .ci_i (carry_q),
        .s_o  (fa_s),
        .co_o (fa_co)
    );

    always_comb begin
        state_d   = state_q;
        shift_a_d = shift_a_q;
        shift_b_d = shift_b_q;
        acc_d     = acc_q;
        result_d  = result_q;
        cnt_d     = cnt_q;
        carry_d   = carry_q;
        op_sub_d  = op_sub_q;
        cout_d    = cout_q;
        ovf_d     = ovf_q;
        busy_o    = 1'b0;
        done_o    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    shift_a_d = a_i;
                    shift_b_d = sub_i ? ~b_i : b_i;
                    carry_d   = sub_i;
                    op_sub_d  = sub_i;
                    cnt_d     = '0;
                    acc_d     = '0;
                    state_d   = StRun;
                end
            end
            StRun: begin
                busy_o    = 1'b1;
                // Sum bits enter at the MSB so after WIDTH shifts bit 0 sits at the LSB.
                acc_d     = {fa_s, acc_q[WIDTH-1:1]};
                shift_a_d = {1'b0, shift_a_q[WIDTH-1:1]};
                shift_b_d = {1'b0, shift_b_q[WIDTH-1:1]};
                carry_d   = fa_co;
                cnt_d     = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    // Visible outputs change only here; the accumulator hides the shifting.
                    result_d = {fa_s, acc_q[WIDTH-1:1]};
                    ovf_d    = carry_q ^ fa_co;
                    cout_d   = fa_co ^ op_sub_q;
                    state_d  = StDone;
                end
            end
            StDone: begin
                done_o  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            shift_a_q <= '0;
            shift_b_q <= '0;
            acc_q     <= '0;
            result_q  <= '0;
            cnt_q     <= '0;
            carry_q   <= 1'b0;
            op_sub_q  <= 1'b0;
            cout_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_a_q <= shift_a_d;
            shift_b_q <= shift_b_d;
            acc_q     <= acc_d;
            result_q  <= result_d;
            cnt_q     <= cnt_d;
            carry_q   <= carry_d;
            op_sub_q  <= op_sub_d;
            cout_q    <= cout_d;
            ovf_q     <= ovf_d;
        end
    end

    assign result_o = result_q;
    assign cout_o   = cout_q;
    assign ovf_o    = ovf_q;
endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Self-checking bench for serial_addsub_ctrl: directed vectors, random operations against an
// arithmetic reference model, start-ignore scenarios and asynchronous reset mid-operation.
module tb_serial_addsub_ctrl;
    localparam int W = 4;
    localparam int BUDGET = 3 * W + 10;

    logic         clk_i = 1'b0;
    logic         rst_ni = 1'b0;
    logic         start_i = 1'b0;
    logic         sub_i = 1'b0;
    logic [W-1:0] a_i = '0;
    logic [W-1:0] b_i = '0;
    logic         busy_o, done_o, cout_o, ovf_o;
    logic [W-1:0] result_o;

    int n_checks = 0;
    int n_fail = 0;

    serial_addsub_ctrl #(.WIDTH(W)) dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .start_i  (start_i),
        .sub_i    (sub_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .result_o (result_o),
        .cout_o   (cout_o),
        .ovf_o    (ovf_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference: plain integer arithmetic on unsigned and signed views of the operands.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         output logic [W-1:0] r, output logic c, output logic o);
        int ua, ub, sa, sb, u, ex;
        ua = int'(a);
        ub = int'(b);
        sa = a[W-1] ? ua - (1 << W) : ua;
        sb = b[W-1] ? ub - (1 << W) : ub;
        u  = s ? ua - ub : ua + ub;
        ex = s ? sa - sb : sa + sb;
        r  = W'(u & ((1 << W) - 1));
        c  = s ? (ua < ub) : (u >= (1 << W));
        o  = (ex < -(1 << (W - 1))) || (ex > (1 << (W - 1)) - 1);
    endtask

    // Stimulus driver only: issues one op and reports what was observed.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         output logic [W-1:0] r, output logic c, output logic o,
                         output int busy_n, output int lat, output bit both_hi,
                         output bit unstable);
        logic [W-1:0] prev_r;
        logic         prev_c, prev_o;
        busy_n = 0; lat = -1; both_hi = 0; unstable = 0;
        prev_r = result_o; prev_c = cout_o; prev_o = ovf_o;
        a_i = a; b_i = b; sub_i = s; start_i = 1'b1;
        @(posedge clk_i);
        #1 start_i = 1'b0;
        a_i = W'($urandom); b_i = W'($urandom); sub_i = 1'($urandom);
        for (int i = 0; i < BUDGET; i++) begin
            @(negedge clk_i);
            if (busy_o) busy_n++;
            if (busy_o && done_o) both_hi = 1;
            if (done_o) begin
                lat = i + 1;
                break;
            end
            if (result_o !== prev_r || cout_o !== prev_c || ovf_o !== prev_o) unstable = 1;
        end
        r = result_o; c = cout_o; o = ovf_o;
        @(negedge clk_i);
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        #2;
        n_checks++;
        if ({busy_o, done_o, result_o, cout_o, ovf_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got busy=%b done=%b result=%b cout=%b ovf=%b, want all 0",
                     busy_o, done_o, result_o, cout_o, ovf_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic test_directed();
        logic [W-1:0] ta [6] = '{4'd5, 4'd15, 4'd0, 4'd7, 4'd3, 4'd8};
        logic [W-1:0] tb [6] = '{4'd3, 4'd1, 4'd0, 4'd2, 4'd5, 4'd1};
        logic         ts [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [W-1:0] xr [6] = '{4'b1000, 4'b0000, 4'b0000, 4'b0101, 4'b1110, 4'b0111};
        logic         xc [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic         xo [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [W-1:0] r;
        logic         c, o;
        int           bn, lat;
        bit           both, unst;
        for (int i = 0; i < 6; i++) begin
            do_op(ta[i], tb[i], ts[i], r, c, o, bn, lat, both, unst);
            n_checks++;
            if ({r, c, o} !== {xr[i], xc[i], xo[i]}) begin
                n_fail++;
                $display("FAIL directed_%0d: got result=%b cout=%b ovf=%b, want %b %b %b",
                         i, r, c, o, xr[i], xc[i], xo[i]);
            end
            n_checks++;
            if (bn !== W || lat !== W + 1 || both || unst) begin
                n_fail++;
                $display("FAIL directed_timing_%0d: busy=%0d lat=%0d both=%0d unstable=%0d, want %0d %0d 0 0",
                         i, bn, lat, both, unst, W, W + 1);
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] a, b, r, er;
        logic         s, c, o, ec, eo;
        int           bn, lat;
        bit           both, unst;
        for (int i = 0; i < 40; i++) begin
            a = W'($urandom); b = W'($urandom); s = 1'($urandom);
            model(a, b, s, er, ec, eo);
            do_op(a, b, s, r, c, o, bn, lat, both, unst);
            n_checks++;
            if ({r, c, o} !== {er, ec, eo} || bn !== W || lat !== W + 1 || both || unst) begin
                n_fail++;
                $display("FAIL random_%0d a=%0d b=%0d sub=%b: got %b %b %b busy=%0d lat=%0d, want %b %b %b busy=%0d lat=%0d",
                         i, a, b, s, r, c, o, bn, lat, er, ec, eo, W, W + 1);
            end
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        lat = -1;
        a_i = 4'd5; b_i = 4'd3; sub_i = 1'b0; start_i = 1'b1;
        @(posedge clk_i);
        #1 a_i = 4'd1; b_i = 4'd1; sub_i = 1'b1;  // start held high into RUN
        for (int i = 0; i < BUDGET; i++) begin
            @(negedge clk_i);
            a_i = W'($urandom); b_i = W'($urandom);
            if (done_o) begin
                lat = i + 1;
                break;
            end
        end
        n_checks++;
        if (result_o !== 4'b1000 || cout_o !== 1'b0 || ovf_o !== 1'b1 || lat !== W + 1) begin
            n_fail++;
            $display("FAIL ignore_in_run: got result=%b cout=%b ovf=%b lat=%0d, want 1000 0 1 %0d",
                     result_o, cout_o, ovf_o, lat, W + 1);
        end
        // Start is high during DONE: must be ignored.
        a_i = 4'd1; b_i = 4'd1; sub_i = 1'b1;
        @(negedge clk_i);
        n_checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || result_o !== 4'b1000) begin
            n_fail++;
            $display("FAIL ignore_in_done: got busy=%b done=%b result=%b, want 0 0 1000",
                     busy_o, done_o, result_o);
        end
        // Start still high now in IDLE, one cycle after done: accepted.
        @(negedge clk_i);
        start_i = 1'b0;
        n_checks++;
        if (busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL accept_after_done: got busy=%b, want 1", busy_o);
        end
        lat = -1;
        for (int i = 0; i < BUDGET; i++) begin
            @(negedge clk_i);
            if (done_o) begin
                lat = i + 1;
                break;
            end
        end
        n_checks++;
        if (result_o !== 4'b0000 || cout_o !== 1'b0 || ovf_o !== 1'b0 || lat !== W) begin
            n_fail++;
            $display("FAIL accept_after_done_result: got result=%b cout=%b ovf=%b lat=%0d, want 0000 0 0 %0d",
                     result_o, cout_o, ovf_o, lat, W);
        end
        @(negedge clk_i);
    endtask

    task automatic test_reset_mid_run();
        logic [W-1:0] r;
        logic         c, o;
        int           bn, lat;
        bit           both, unst, saw_done;
        // Leave nonzero outputs so the clear is observable.
        do_op(4'd15, 4'd1, 1'b0, r, c, o, bn, lat, both, unst);
        a_i = 4'd5; b_i = 4'd3; sub_i = 1'b0; start_i = 1'b1;
        @(posedge clk_i);
        #1 start_i = 1'b0;
        @(posedge clk_i);
        @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        n_checks++;
        if ({busy_o, done_o, result_o, cout_o, ovf_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_run: got busy=%b done=%b result=%b cout=%b ovf=%b, want all 0",
                     busy_o, done_o, result_o, cout_o, ovf_o);
        end
        saw_done = 0;
        repeat (3) begin
            @(negedge clk_i);
            if (done_o || busy_o) saw_done = 1;
        end
        rst_ni = 1'b1;
        repeat (W + 3) begin
            @(negedge clk_i);
            if (done_o || busy_o) saw_done = 1;
        end
        n_checks++;
        if (saw_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_no_done: got activity=%0d, want 0", saw_done);
        end
        do_op(4'd2, 4'd2, 1'b0, r, c, o, bn, lat, both, unst);
        n_checks++;
        if ({r, c, o} !== {4'b0100, 1'b0, 1'b0} || lat !== W + 1 || bn !== W) begin
            n_fail++;
            $display("FAIL post_reset_add: got result=%b cout=%b ovf=%b lat=%0d busy=%0d, want 0100 0 0 %0d %0d",
                     r, c, o, lat, bn, W + 1, W);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
